// File: rtl/hyperbus_arb_pkg.sv
// hyperbus_arb_pkg: shared state enum, port count and default watchdog limit for the hyperbus arbiter
package hyperbus_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;
  localparam int NPORTS = 2;
  localparam int DEFAULT_TIMEOUT = 1024;
endpackage

// File: rtl/hyperbus_rr_pick.sv
// hyperbus_rr_pick: two-way round-robin selector (req, last_grant in; gnt index, gnt_valid out)
module hyperbus_rr_pick
  import hyperbus_arb_pkg::*;
(
  input  logic [NPORTS-1:0] req,
  input  logic              last_grant,
  output logic              gnt,
  output logic              gnt_valid
);
  always_comb begin
    gnt = &req ? ~last_grant : req[1];
    gnt_valid = |req;
  end
endmodule

// File: rtl/hyperbus_arbiter.sv
// hyperbus_arbiter: two-port round-robin front end for one hyperbus controller (pN_* requester ports, hbus_* controller port, TIMEOUT watchdog)
module hyperbus_arbiter
  import hyperbus_arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_rrq,
  input  logic        p0_wrq,
  input  logic [31:0] p0_adr_i,
  input  logic [15:0] p0_dat_i,
  input  logic        p0_mask_i,
  input  logic        p0_reg_space_i,
  output logic        p0_ack,
  output logic        p0_err,
  output logic        p0_valid,
  output logic [15:0] p0_dat_o,
  input  logic        p1_rrq,
  input  logic        p1_wrq,
  input  logic [31:0] p1_adr_i,
  input  logic [15:0] p1_dat_i,
  input  logic        p1_mask_i,
  input  logic        p1_reg_space_i,
  output logic        p1_ack,
  output logic        p1_err,
  output logic        p1_valid,
  output logic [15:0] p1_dat_o,
  output logic        hbus_rrq,
  output logic        hbus_wrq,
  output logic [31:0] hbus_adr_o,
  output logic [15:0] hbus_dat_o,
  output logic        hbus_mask_o,
  output logic        hbus_reg_space_o,
  input  logic [15:0] hbus_dat_i,
  input  logic        hbus_ready,
  input  logic        hbus_valid
);
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [WW-1:0] wd;
  logic [NPORTS-1:0] req;
  logic last_grant, grant, op_write, seen_busy, pick, pick_valid;
  logic start, finish, timeout, capture, sel_wr;
  assign req = {p1_rrq | p1_wrq, p0_rrq | p0_wrq};
  hyperbus_rr_pick u_pick (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (pick),
    .gnt_valid  (pick_valid)
  );
  always_comb begin
    start = state == IDLE && hbus_ready && pick_valid;
    sel_wr = pick ? p1_wrq : p0_wrq;
    finish = state == BUSY && seen_busy && hbus_ready;
    timeout = state == BUSY && !finish && wd == WW'(TIMEOUT - 1);
    capture = (state == ISSUE || state == BUSY) && !op_write && hbus_valid && !timeout;
    state_n = start ? ISSUE :
              state == ISSUE ? BUSY :
              (finish || timeout) ? DONE :
              state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      grant <= 1'b0;
      op_write <= 1'b0;
      seen_busy <= 1'b0;
      wd <= '0;
      hbus_rrq <= 1'b0;
      hbus_wrq <= 1'b0;
      hbus_adr_o <= '0;
      hbus_dat_o <= '0;
      hbus_mask_o <= 1'b0;
      hbus_reg_space_o <= 1'b0;
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      p0_err <= 1'b0;
      p1_err <= 1'b0;
      p0_valid <= 1'b0;
      p1_valid <= 1'b0;
      p0_dat_o <= '0;
      p1_dat_o <= '0;
    end else begin
      state <= state_n;
      hbus_rrq <= start && !sel_wr;
      hbus_wrq <= start && sel_wr;
      if (start) begin
        grant <= pick;
        op_write <= sel_wr;
        hbus_adr_o <= pick ? p1_adr_i : p0_adr_i;
        hbus_dat_o <= pick ? p1_dat_i : p0_dat_i;
        hbus_mask_o <= pick ? p1_mask_i : p0_mask_i;
        hbus_reg_space_o <= pick ? p1_reg_space_i : p0_reg_space_i;
      end
      wd <= state == BUSY ? wd + 1'b1 : '0;
      seen_busy <= state == BUSY && (seen_busy || !hbus_ready);
      p0_ack <= finish && !grant;
      p1_ack <= finish && grant;
      p0_err <= timeout && !grant;
      p1_err <= timeout && grant;
      p0_valid <= capture && !grant;
      p1_valid <= capture && grant;
      if (capture && !grant) p0_dat_o <= hbus_dat_i;
      if (capture && grant) p1_dat_o <= hbus_dat_i;
      if (finish || timeout) last_grant <= grant;
    end
  end
endmodule
